// File: rtl/jtag_shift_serializer_if.sv
// Load/shift/status bundle for jtag_shift_serializer.
//   master : the DR capture logic / TAP controller side
//            (drives load_valid, load_data, load_len, shift_en and abort).
//   slave  : the serializer itself
//            (drives load_ready, tdo, busy, done and bits_left).
interface jtag_shift_serializer_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
);

   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic [CNT_W-1:0] load_len;
   logic             shift_en;
   logic             abort;
   logic             tdo;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] bits_left;

   modport master (
      output load_valid, load_data, load_len, shift_en, abort,
      input  load_ready, tdo, busy, done, bits_left
   );

   modport slave (
      input  load_valid, load_data, load_len, shift_en, abort,
      output load_ready, tdo, busy, done, bits_left
   );

endinterface

// File: rtl/jtag_shift_serializer.sv
// TDO serializer for the JTAG data-register path.
// Accepts a WIDTH-bit word and a bit length through a valid/ready load handshake. It then
// shifts the bits out on tdo on every posedge where shift_en is high. When the last bit has
// been consumed it raises a one-cycle done pulse.
// Ports:
//   clk    TCK-domain clock
//   reset  synchronous, active-high; has priority over everything else
//   bus    jtag_shift_serializer_if slave modport:
//            load_valid/load_ready/load_data/load_len  load handshake
//            shift_en   high while the TAP is in Shift-DR; low pauses shifting
//            abort      drops the current transfer without a done pulse
//            tdo        serial output, updated on negedge clk only
//            busy       transfer in progress
//            done       one-cycle pulse after the last bit is consumed
//            bits_left  number of bits not yet consumed
module jtag_shift_serializer #(
   parameter int unsigned WIDTH     = 32,
   parameter bit          LSB_FIRST = 1'b0,
   parameter int unsigned CNT_W     = $clog2(WIDTH + 1)
) (
   input logic                    clk,
   input logic                    reset,
   jtag_shift_serializer_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             done_q,  done_d;
   logic             tdo_q;

   logic [CNT_W-1:0] eff_len;
   logic [CNT_W-1:0] shamt;
   logic             head;

   // A length of 0, or one above WIDTH, means a full-width transfer.
   always_comb begin
      if (bus.load_len == '0 || bus.load_len > CNT_W'(WIDTH)) begin
         eff_len = CNT_W'(WIDTH);
      end else begin
         eff_len = bus.load_len;
      end
   end

   // MSB-first: left-align the word so bit eff_len-1 sits at shreg[WIDTH-1].
   assign shamt = CNT_W'(WIDTH) - eff_len;
   assign head  = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      count_d = count_q;
      done_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.load_valid) begin
               state_d = StShift;
               count_d = eff_len;
               shreg_d = LSB_FIRST ? bus.load_data : (bus.load_data << shamt);
            end
         end
         StShift: begin
            if (bus.abort) begin
               state_d = StIdle;
               count_d = '0;
            end else if (bus.shift_en) begin
               // Shift toward the head end and fill with zeros.
               shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
               count_d = count_q - CNT_W'(1);
               if (count_q == CNT_W'(1)) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         shreg_q <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   // The bit is launched on the negedge, so it is stable at the posedge where the
   // receiver samples it and where the shifter consumes it.
   always_ff @(negedge clk) begin
      tdo_q <= (state_q == StShift && !reset) ? head : 1'b0;
   end

   assign bus.load_ready = (state_q == StIdle) && !reset;
   assign bus.busy       = (state_q == StShift);
   assign bus.done       = done_q;
   assign bus.bits_left  = count_q;
   assign bus.tdo        = tdo_q;

endmodule

// File: tb/tb_jtag_shift_serializer.sv
module tb_jtag_shift_serializer;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 6;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic             load_valid = 1'b0;
   logic [WIDTH-1:0] load_data  = '0;
   logic [CNT_W-1:0] load_len   = '0;
   logic             shift_en   = 1'b0;
   logic             abort      = 1'b0;

   jtag_shift_serializer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus_m ();
   jtag_shift_serializer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus_l ();

   assign bus_m.load_valid = load_valid;
   assign bus_m.load_data  = load_data;
   assign bus_m.load_len   = load_len;
   assign bus_m.shift_en   = shift_en;
   assign bus_m.abort      = abort;
   assign bus_l.load_valid = load_valid;
   assign bus_l.load_data  = load_data;
   assign bus_l.load_len   = load_len;
   assign bus_l.shift_en   = shift_en;
   assign bus_l.abort      = abort;

   jtag_shift_serializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b0), .CNT_W(CNT_W)) u_dut_msb (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_m)
   );

   jtag_shift_serializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b1), .CNT_W(CNT_W)) u_dut_lsb (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_l)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model, index 0 = MSB-first, 1 = LSB-first.
   // A transfer is the list of bits in the order they leave tdo, plus a position in that list.
   typedef enum int {MIdle, MShift, MDone} mstate_e;
   mstate_e     m_st   [2];
   logic [31:0] m_seq  [2];
   int          m_len  [2];
   int          m_pos  [2];
   logic        m_done [2];

   function automatic logic [31:0] bit_order(input logic [31:0] data, input int n, input bit lsb);
      logic [31:0] s;
      s = '0;
      for (int k = 0; k < n; k++) begin
         s[k] = lsb ? data[k] : data[n-1-k];
      end
      return s;
   endfunction

   // One clock: predict tdo for this posedge, advance the model, then compare.
   task automatic step();
      logic exp_tdo [2];
      int   eff;
      for (int i = 0; i < 2; i++) begin
         exp_tdo[i] = (!reset && m_st[i] == MShift) ? m_seq[i][m_pos[i]] : 1'b0;
      end
      @(posedge clk);
      eff = (load_len == 0 || int'(load_len) > int'(WIDTH)) ? int'(WIDTH) : int'(load_len);
      for (int i = 0; i < 2; i++) begin
         m_done[i] = 1'b0;
         if (reset) begin
            m_st[i]  = MIdle;
            m_len[i] = 0;
            m_pos[i] = 0;
         end else begin
            case (m_st[i])
               MIdle: begin
                  if (load_valid) begin
                     m_st[i]  = MShift;
                     m_len[i] = eff;
                     m_pos[i] = 0;
                     m_seq[i] = bit_order(load_data, eff, i == 1);
                  end
               end
               MShift: begin
                  if (abort) begin
                     m_st[i]  = MIdle;
                     m_len[i] = 0;
                     m_pos[i] = 0;
                  end else if (shift_en) begin
                     m_pos[i]++;
                     if (m_pos[i] == m_len[i]) begin
                        m_st[i]   = MDone;
                        m_done[i] = 1'b1;
                     end
                  end
               end
               default: m_st[i] = MIdle;
            endcase
         end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         logic       o_tdo, o_busy, o_done, o_rdy;
         logic [5:0] o_left;
         string      p;
         p      = (i == 0) ? "msb" : "lsb";
         o_tdo  = (i == 0) ? bus_m.tdo        : bus_l.tdo;
         o_busy = (i == 0) ? bus_m.busy       : bus_l.busy;
         o_done = (i == 0) ? bus_m.done       : bus_l.done;
         o_rdy  = (i == 0) ? bus_m.load_ready : bus_l.load_ready;
         o_left = (i == 0) ? bus_m.bits_left  : bus_l.bits_left;
         check({p, ".tdo"},        32'(o_tdo),  32'(exp_tdo[i]));
         check({p, ".busy"},       32'(o_busy), 32'(m_st[i] == MShift));
         check({p, ".done"},       32'(o_done), 32'(m_done[i]));
         check({p, ".bits_left"},  32'(o_left), 32'(m_len[i] - m_pos[i]));
         check({p, ".load_ready"}, 32'(o_rdy),  32'(m_st[i] == MIdle && !reset));
      end
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic load(input logic [31:0] data, input logic [5:0] len);
      load_valid = 1'b1;
      load_data  = data;
      load_len   = len;
      step();
      load_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_st[i]   = MIdle;
         m_seq[i]  = '0;
         m_len[i]  = 0;
         m_pos[i]  = 0;
         m_done[i] = 1'b0;
      end
      // Let the negedge tdo flop see reset once before comparing.
      repeat (2) @(posedge clk);
      #1;
      steps(2);
      reset = 1'b0;
      steps(2);

      // Full-width MSB-first via len=0.
      shift_en = 1'b1;
      load(32'hA5A5_0F0F, 6'd0);
      steps(36);

      // Byte transfer, LSB instance gives 0,0,1,0,1,1,0,1.
      load(32'h0000_00B4, 6'd8);
      steps(12);

      // Short transfer, upper bits must not leak out.
      load(32'hFFFF_FF13, 6'd5);
      steps(8);

      // Pause after 3 bits for 4 cycles.
      load(32'h0000_00FF, 6'd8);
      steps(3);
      shift_en = 1'b0;
      steps(4);
      shift_en = 1'b1;
      steps(8);

      // Abort after 10 bits, reload straight away.
      load(32'hA5A5_0F0F, 6'd32);
      steps(10);
      abort = 1'b1;
      step();
      abort = 1'b0;
      load(32'h1234_5678, 6'd16);
      steps(20);

      // Loads while busy are ignored; reset mid-transfer gives no done.
      load(32'hDEAD_BEEF, 6'd0);
      steps(5);
      load_valid = 1'b1;
      load_data  = 32'h0F0F_F0F0;
      load_len   = 6'd12;
      steps(3);
      reset = 1'b1;
      step();
      reset      = 1'b0;
      load_valid = 1'b0;
      steps(4);

      // Randomized traffic, including over-long lengths.
      for (int n = 0; n < 3000; n++) begin
         load_valid = ($urandom_range(0, 1) == 1);
         load_data  = $urandom();
         load_len   = 6'($urandom_range(0, 40));
         shift_en   = ($urandom_range(0, 9) < 7);
         abort      = ($urandom_range(0, 99) < 3);
         reset      = ($urandom_range(0, 199) == 0);
         step();
      end
      reset = 1'b0;
      abort = 1'b0;
      steps(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
